// File: rtl/bubble_sort_pkg.sv
// Shared constants and types for the bubble sort core.
// Build option: define SORT_DESCEND_EN for largest-first output.
package bubble_sort_pkg;

    localparam int unsigned N_DEF = 16;
    localparam int unsigned DW    = 8;

    typedef logic [DW-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        OUTPUT
    } state_e;

endpackage

// File: rtl/cmp_swap.sv
// Compare-and-swap cell of the odd-even transposition network.
// Ports:
//   a_i, b_i    : element pair at positions (i, i+1)
//   first_c_o   : value that belongs at position i after the step
//   second_c_o  : value that belongs at position i+1 after the step
// Build option: SORT_DESCEND_EN puts the larger value first.
module cmp_swap
    import bubble_sort_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] first_c_o,
    output logic [DW-1:0] second_c_o
);

    logic swap_c;

    // Equal values never swap, so duplicates keep their relative order.
`ifdef SORT_DESCEND_EN
    assign swap_c = (a_i < b_i);
`else
    assign swap_c = (a_i > b_i);
`endif

    assign first_c_o  = swap_c ? b_i : a_i;
    assign second_c_o = swap_c ? a_i : b_i;

endmodule

// File: rtl/bubble_sort_core.sv
// Serial-in / serial-out block sorter using an odd-even transposition network.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : in_data carries an element (accepted in IDLE/LOAD only)
//   in_data     : unsigned element
//   out_valid   : out_data carries a sorted element (registered)
//   out_data    : sorted element, 0 when out_valid is low (registered)
// Build option: SORT_DESCEND_EN selects largest-first output.
module bubble_sort_core
    import bubble_sort_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data
);

    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned IW = $clog2(N);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    elem_t           elem_q [N];
    elem_t           elem_d [N];
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;

    elem_t           first_c  [N-1];
    elem_t           second_c [N-1];

    // One cell per adjacent pair; even pairs fire on even steps, odd pairs on odd steps.
    for (genvar i = 0; i < int'(N) - 1; i++) begin : g_cmp
        cmp_swap u_cmp_swap (
            .a_i        (elem_q[i]),
            .b_i        (elem_q[i+1]),
            .first_c_o  (first_c[i]),
            .second_c_o (second_c[i])
        );
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        elem_d      = elem_q;
        out_valid_d = 1'b0;
        out_data_d  = 8'd0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    elem_d[0] = in_data;
                    cnt_d     = CW'(1);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    elem_d[cnt_q[IW-1:0]] = in_data;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = SORT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SORT: begin
                // cnt_q is the step index; its LSB selects the pair phase.
                for (int i = 0; i < int'(N) - 1; i++) begin
                    if (i[0] == cnt_q[0]) begin
                        elem_d[i]   = first_c[i];
                        elem_d[i+1] = second_c[i];
                    end
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = OUTPUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUTPUT: begin
                // Count N emits, then one extra cycle to drop out_valid before re-arming.
                if (cnt_q == CW'(N)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = elem_q[cnt_q[IW-1:0]];
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, storage and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            for (int i = 0; i < int'(N); i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            elem_q      <= elem_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_bubble_sort_core.sv
// Self-checking bench for bubble_sort_core: table-driven blocks, scoreboard on the output stream.
module tb_bubble_sort_core;

    localparam int N = 16;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;

    bubble_sort_core #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din  [N];
        logic [7:0] dout [N];
        bit         gap;
        bit         spur;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mon_e;

    task automatic check(input string name, input int got, input int req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got=%0d required=%0d at %0t", name, got, req, $time);
        end
    endtask

    // Scoreboard: every output beat is popped and compared; idle beats must read 0.
    always @(negedge clk) begin
        if (rst_n) begin
            n_vec++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out got=%0d required=no_output at %0t", out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e) begin
                        n_err++;
                        $display("FAIL out_data got=%0d required=%0d at %0t", out_data, mon_e, $time);
                    end
                end
            end else if (out_data !== 8'd0) begin
                n_err++;
                $display("FAIL idle_data got=%0d required=0 at %0t", out_data, $time);
            end
        end
    end

    // Reference: insertion sort, ascending.
    task automatic sort_model(input logic [7:0] a [N], output logic [7:0] s [N]);
        logic [7:0] key;
        int         j;
        s = a;
        for (int i = 1; i < N; i++) begin
            key = s[i];
            j   = i - 1;
            while (j >= 0 && s[j] > key) begin
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = key;
        end
    endtask

    task automatic push_expected(input logic [7:0] dsort [N]);
        for (int i = 0; i < N; i++) begin
`ifdef SORT_DESCEND_EN
            exp_q.push_back(dsort[N-1-i]);
`else
            exp_q.push_back(dsort[i]);
`endif
        end
    endtask

    task automatic drive_block(input logic [7:0] din [N], input bit gap);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = din[i];
            @(posedge clk); #1;
            if (gap && i != N - 1) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                @(posedge clk); #1;
            end
        end
    endtask

    // One full block: load, check latency from the N-th sample and burst length.
    task automatic run_block(input logic [7:0] din [N], input logic [7:0] dsort [N],
                             input bit gap, input bit spur);
        int lat;
        int run;
        push_expected(dsort);
        drive_block(din, gap);
        if (spur) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'd0;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 4 * N);
        check("latency", lat, N + 1);
        run = 0;
        while (out_valid && run < 4 * N) begin
            run++;
            @(posedge clk); #1;
        end
        check("burst_len", run, N);
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    // Reset in the middle of a block: outputs clear at once and nothing follows.
    task automatic abort_block(input logic [7:0] din [N], input logic [7:0] dsort [N],
                               input bit in_output);
        int lat;
        if (in_output) push_expected(dsort);
        drive_block(din, 1'b0);
        in_valid = 1'b0;
        in_data  = 8'd0;
        if (in_output) begin
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!out_valid && lat < 4 * N);
            check("abort_latency", lat, N + 1);
            repeat (3) begin
                @(posedge clk); #1;
            end
        end else begin
            repeat (5) begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_data", int'(out_data), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3 * N) begin
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] rin  [N];
    logic [7:0] rout [N];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        tbl[0].din  = '{8'd5, 8'd3, 8'd200, 8'd0, 8'd17, 8'd17, 8'd255, 8'd1,
                        8'd9, 8'd8, 8'd100, 8'd42, 8'd7, 8'd6, 8'd2, 8'd4};
        tbl[0].dout = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                        8'd8, 8'd9, 8'd17, 8'd17, 8'd42, 8'd100, 8'd200, 8'd255};
        tbl[0].gap  = 1'b0;
        tbl[0].spur = 1'b0;
        for (int i = 0; i < N; i++) begin
            tbl[1].din[i]  = 8'(255 - i);
            tbl[1].dout[i] = 8'(240 + i);
        end
        tbl[1].gap  = 1'b0;
        tbl[1].spur = 1'b0;
        tbl[2].din  = tbl[0].din;
        tbl[2].dout = tbl[0].dout;
        tbl[2].gap  = 1'b1;
        tbl[2].spur = 1'b0;
        tbl[3].din  = '{8'd7, 8'd7, 8'd0, 8'd255, 8'd128, 8'd7, 8'd0, 8'd255,
                        8'd1, 8'd2, 8'd3, 8'd128, 8'd64, 8'd64, 8'd9, 8'd10};
        tbl[3].dout = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd7, 8'd7,
                        8'd9, 8'd10, 8'd64, 8'd64, 8'd128, 8'd128, 8'd255, 8'd255};
        tbl[3].gap  = 1'b0;
        tbl[3].spur = 1'b1;
        for (int i = 0; i < N; i++) begin
            tbl[4].din[i]  = 8'h55;
            tbl[4].dout[i] = 8'h55;
        end
        tbl[4].gap  = 1'b1;
        tbl[4].spur = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", int'(out_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_valid", int'(out_valid), 0);

        // Table blocks run back-to-back: each starts the cycle after out_valid falls.
        for (int t = 0; t < 5; t++) begin
            run_block(tbl[t].din, tbl[t].dout, tbl[t].gap, tbl[t].spur);
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                rin[i] = (r == 2) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            end
            sort_model(rin, rout);
            run_block(rin, rout, r[0], 1'b0);
        end

        abort_block(tbl[1].din, tbl[1].dout, 1'b0);
        run_block(tbl[0].din, tbl[0].dout, 1'b0, 1'b0);
        abort_block(tbl[3].din, tbl[3].dout, 1'b1);
        run_block(tbl[3].din, tbl[3].dout, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
